conv3x3_stream_array: RTL and testbench



---
 rtl/conv3x3_stream_array_pkg.sv | 31 +++
 rtl/conv_line_buffer.sv | 38 +++
 rtl/conv3x3_stream_array.sv | 240 ++++++++++++++++++++++++
 tb/tb_conv3x3_stream_array.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_stream_array_pkg.sv
// Shared definitions for the streaming 3x3 convolution array: FSM encoding,
// weight-index constants and compile-time width helpers.
package conv3x3_stream_array_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  localparam logic [3:0] TAP_1X1 = 4'd9;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int prod_w(input int dw, input int ww);
    return dw + ww;
  endfunction

  // Four guard bits cover the growth of a nine-term sum.
  function automatic int sum_w(input int dw, input int ww);
    return dw + ww + 4;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Circular delay line whose length is set at runtime (1..DEPTH); the output
// is the sample written exactly i_len enables earlier.
module conv_line_buffer
  import conv3x3_stream_array_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 56
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic [clog2(DEPTH+1)-1:0] i_len,
  input  logic signed [DW-1:0]      i_data,
  output logic signed [DW-1:0]      o_data
);

  localparam int AW = clog2(DEPTH);

  logic signed [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_ptr;

  // Read-before-write at the same slot yields the oldest stored sample.
  assign o_data = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == AW'(i_len - 1'b1)) ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) r_mem[r_ptr] <= i_data;
  end

endmodule

// File: rtl/conv3x3_stream_array.sv
// Streaming 3x3 convolution with zero padding; emits the 3x3 sum, the 1x1
// product and the identity pixel together for downstream branch fusion.
module conv3x3_stream_array
  import conv3x3_stream_array_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int WW    = 8,
  parameter  int MAX_W = 56,
  parameter  int MAX_H = 56,
  localparam int PW    = prod_w(DW, WW),
  localparam int SW    = sum_w(DW, WW),
  localparam int XW    = clog2(MAX_W + 1),
  localparam int YW    = clog2(MAX_H + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XW-1:0]        cfg_width,
  input  logic [YW-1:0]        cfg_height,
  input  logic                 start,
  output logic                 cfg_err,
  output logic                 busy,
  input  logic                 w_we,
  input  logic [3:0]           w_idx,
  input  logic signed [WW-1:0] w_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [SW-1:0] psum_3x3,
  output logic signed [PW-1:0] product_1x1,
  output logic signed [DW-1:0] identity,
  output logic                 out_last
);

  localparam int CW = clog2(MAX_W * MAX_H + 1);

  function automatic logic signed [PW-1:0] tap_mul(input logic en,
                                                   input logic signed [DW-1:0] a,
                                                   input logic signed [WW-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    if (!en) return '0;
    return p;
  endfunction

  function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] p);
    return SW'(p);
  endfunction

  state_t               r_state;
  logic                 r_busy, r_cfg_err;
  logic [XW-1:0]        r_w, r_cc, r_fcnt;
  logic [YW-1:0]        r_h, r_cr;
  logic [CW-1:0]        r_npix, r_nin;
  logic signed [WW-1:0] r_wt [10];

  logic                 w_stall, w_acc, w_adv, w_win_vld, w_cfg_ok, w_start_ok, w_last;
  logic signed [DW-1:0] w_px, w_lb0, w_lb1;
  logic [2:0]           w_row_ok, w_col_ok;
  logic [8:0]           w_mask;

  logic signed [DW-1:0] r_win_p0 [3][3];
  logic [8:0]           r_mask_p0;
  logic                 r_last_p0, r_vld_p0;
  logic signed [PW-1:0] r_prod_p1 [9];
  logic signed [PW-1:0] r_p1x1_p1, r_p1x1_p2, r_p1x1_p3;
  logic signed [DW-1:0] r_id_p1, r_id_p2, r_id_p3;
  logic                 r_last_p1, r_last_p2, r_last_p3;
  logic                 r_vld_p1, r_vld_p2, r_vld_p3;
  logic signed [SW-1:0] r_rsum_p2 [3];
  logic signed [SW-1:0] r_psum_p3;

  assign w_stall    = r_vld_p3 & ~out_ready;
  assign in_ready   = (r_state == ST_FILL || r_state == ST_RUN) && !w_stall;
  assign w_acc      = in_valid & in_ready;
  assign w_adv      = w_acc | ((r_state == ST_FLUSH) & ~w_stall);
  assign w_px       = (r_state == ST_FLUSH) ? '0 : in_data;
  assign w_win_vld  = (r_state == ST_FLUSH) || (r_nin >= CW'(r_w) + CW'(1));
  assign w_cfg_ok   = (cfg_width >= XW'(2)) && (cfg_height >= YW'(2)) &&
                      (cfg_width <= XW'(MAX_W)) && (cfg_height <= YW'(MAX_H));
  assign w_start_ok = (r_state == ST_IDLE) && start && w_cfg_ok;
  assign w_last     = (r_cr == r_h - 1'b1) && (r_cc == r_w - 1'b1);

  assign busy        = r_busy;
  assign cfg_err     = r_cfg_err;
  assign out_valid   = r_vld_p3;
  assign out_last    = r_last_p3;
  assign psum_3x3    = r_psum_p3;
  assign product_1x1 = r_p1x1_p3;
  assign identity    = r_id_p3;

  always_comb begin
    w_mask   = '0;
    w_row_ok = {r_cr != r_h - 1'b1, 1'b1, r_cr != '0};
    w_col_ok = {r_cc != r_w - 1'b1, 1'b1, r_cc != '0};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_mask[r*3+c] = w_row_ok[r] & w_col_ok[c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_w       <= '0;
      r_h       <= '0;
      r_npix    <= '0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          if (w_cfg_ok) begin
            r_state <= ST_FILL;
            r_busy  <= 1'b1;
            r_w     <= cfg_width;
            r_h     <= cfg_height;
            r_npix  <= CW'(cfg_width) * CW'(cfg_height);
          end else begin
            r_cfg_err <= 1'b1;
          end
        end
        ST_FILL, ST_RUN: if (w_acc) begin
          if (r_nin + CW'(1) == r_npix)                   r_state <= ST_FLUSH;
          else if (r_nin + CW'(1) == CW'(r_w) + CW'(2))  r_state <= ST_RUN;
        end
        ST_FLUSH: if (w_adv && r_fcnt == r_w) r_state <= ST_DRAIN;
        ST_DRAIN: if (r_vld_p3 && out_ready && r_last_p3) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Window-centre coordinates advance only once a complete window exists.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_nin  <= '0;
      r_fcnt <= '0;
      r_cc   <= '0;
      r_cr   <= '0;
    end else begin
      if (w_acc) r_nin <= r_nin + 1'b1;
      if (w_adv && r_state == ST_FLUSH) r_fcnt <= r_fcnt + 1'b1;
      if (w_adv && w_win_vld) begin
        if (r_cc == r_w - 1'b1) begin
          r_cc <= '0;
          r_cr <= (r_cr == r_h - 1'b1) ? '0 : r_cr + 1'b1;
        end else begin
          r_cc <= r_cc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) r_wt[i] <= '0;
    end else if (r_state == ST_IDLE && w_we && w_idx <= TAP_1X1) begin
      r_wt[w_idx] <= w_data;
    end
  end

  conv_line_buffer #(.DW(DW), .DEPTH(MAX_W)) u_lb0 (
    .clk(clk), .rst(rst), .i_clr(w_start_ok), .i_en(w_adv),
    .i_len(r_w), .i_data(w_px), .o_data(w_lb0)
  );

  conv_line_buffer #(.DW(DW), .DEPTH(MAX_W)) u_lb1 (
    .clk(clk), .rst(rst), .i_clr(w_start_ok), .i_en(w_adv),
    .i_len(r_w), .i_data(w_lb0), .o_data(w_lb1)
  );

  // Stage p0: window shift, row 0 = two lines back, row 2 = newest sample.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int r = 0; r < 3; r++) begin
        r_win_p0[r][0] <= r_win_p0[r][1];
        r_win_p0[r][1] <= r_win_p0[r][2];
      end
      r_win_p0[0][2] <= w_lb1;
      r_win_p0[1][2] <= w_lb0;
      r_win_p0[2][2] <= w_px;
      r_mask_p0      <= w_mask;
      r_last_p0      <= w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_last_p2 <= 1'b0;
    end else if (!w_stall) begin
      r_vld_p0  <= w_adv & w_win_vld;
      r_vld_p1  <= r_vld_p0;
      r_vld_p2  <= r_vld_p1;
      r_last_p1 <= r_vld_p0 & r_last_p0;
      r_last_p2 <= r_last_p1;
    end
  end

  // Stage p1: masked products; stage p2: per-row sums.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_prod_p1[r*3+c] <= tap_mul(r_mask_p0[r*3+c], r_win_p0[r][c], r_wt[r*3+c]);
      r_p1x1_p1 <= tap_mul(1'b1, r_win_p0[1][1], r_wt[9]);
      r_id_p1   <= r_win_p0[1][1];
      for (int r = 0; r < 3; r++)
        r_rsum_p2[r] <= sx(r_prod_p1[r*3]) + sx(r_prod_p1[r*3+1]) + sx(r_prod_p1[r*3+2]);
      r_p1x1_p2 <= r_p1x1_p1;
      r_id_p2   <= r_id_p1;
    end
  end

  // Stage p3: final sum and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p3  <= 1'b0;
      r_last_p3 <= 1'b0;
      r_psum_p3 <= '0;
      r_p1x1_p3 <= '0;
      r_id_p3   <= '0;
    end else if (!w_stall) begin
      r_vld_p3  <= r_vld_p2;
      r_last_p3 <= r_last_p2;
      r_psum_p3 <= r_rsum_p2[0] + r_rsum_p2[1] + r_rsum_p2[2];
      r_p1x1_p3 <= r_p1x1_p2;
      r_id_p3   <= r_id_p2;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_array.sv
// Directed bench for conv3x3_stream_array: hand-derived frames with known sums.
module tb_conv3x3_stream_array;

  localparam int DW = 8, WW = 8, MAX_W = 56, MAX_H = 56, PW = 16, SW = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [5:0]           cfg_width, cfg_height;
  logic                 start, cfg_err, busy;
  logic                 w_we;
  logic [3:0]           w_idx;
  logic signed [WW-1:0] w_data;
  logic                 in_valid, in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid, out_ready, out_last;
  logic signed [SW-1:0] psum_3x3;
  logic signed [PW-1:0] product_1x1;
  logic signed [DW-1:0] identity;

  conv3x3_stream_array #(.DW(DW), .WW(WW), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .start(start), .cfg_err(cfg_err), .busy(busy),
    .w_we(w_we), .w_idx(w_idx), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .psum_3x3(psum_3x3), .product_1x1(product_1x1), .identity(identity),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // kind 0: all ones; 1: ramp; 2: all -128; 3: ramp modulo 100
  function automatic int pix_val(input int kind, input int n);
    case (kind)
      0:       return 1;
      1:       return n;
      2:       return -128;
      default: return n % 100;
    endcase
  endfunction

  function automatic int exp_psum(input int kind, input int b, input int w, input int h);
    int r, c;
    r = b / w;
    c = b % w;
    case (kind)
      0:       return ((r == 0 || r == h-1) ? 2 : 3) * ((c == 0 || c == w-1) ? 2 : 3);
      1:       return b;
      2:       return 65536;
      default: return (r == 0) ? 0 : (b - w) % 100;
    endcase
  endfunction

  function automatic int exp_prod(input int kind, input int b);
    case (kind)
      0:       return 2;
      1:       return 3 * b;
      2:       return 16384;
      default: return b % 100;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int idx, input int val);
    w_we = 1'b1; w_idx = 4'(idx); w_data = WW'(val);
    step();
    w_we = 1'b0;
  endtask

  task automatic set_all(input int v3, input int v9);
    for (int i = 0; i < 9; i++) set_w(i, v3);
    set_w(9, v9);
  endtask

  task automatic run_frame(input int w, input int h, input int kind,
                           input bit rnd_ready, input bit mid_poke);
    int pix, beats, cyc;
    cfg_width = 6'(w); cfg_height = 6'(h); start = 1'b1;
    step();
    start = 1'b0;
    check_val("busy_start", busy, 1);
    pix = 0; beats = 0; cyc = 0;
    while (beats < w * h && cyc < 5000) begin
      in_valid  = (pix < w * h);
      in_data   = DW'(pix_val(kind, pix));
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      w_we      = mid_poke && cyc == 1;
      start     = mid_poke && cyc == 1;
      w_idx     = 4'd4;
      w_data    = 8'sd50;
      cfg_width = (mid_poke && cyc == 1) ? 6'd1 : 6'(w);
      #4;
      if (mid_poke && cyc == 2) check_val("busy_start_no_err", cfg_err, 0);
      if (out_valid && !out_ready) check_val("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) pix++;
      if (out_valid && out_ready) begin
        check_val($sformatf("psum_k%0d_b%0d", kind, beats), psum_3x3, exp_psum(kind, beats, w, h));
        check_val($sformatf("p1x1_k%0d_b%0d", kind, beats), product_1x1, exp_prod(kind, beats));
        check_val($sformatf("id_k%0d_b%0d", kind, beats), identity, pix_val(kind, beats));
        check_val($sformatf("last_k%0d_b%0d", kind, beats), out_last, (beats == w*h-1) ? 1 : 0);
        beats++;
      end
      @(posedge clk);
      #1;
      w_we = 1'b0; start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_val($sformatf("beats_k%0d", kind), beats, w * h);
    check_val("busy_end", busy, 0);
    check_val("valid_end", out_valid, 0);
  endtask

  initial begin
    int acc, cyc;
    rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
    w_we = 1'b0; w_idx = '0; w_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) step();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_cfg_err", cfg_err, 0);
    check_val("rst_psum", psum_3x3, 0);
    check_val("rst_last", out_last, 0);
    rst = 1'b0;
    step();

    // 4x4 of ones, all taps 1: corners 4, edges 6, interior 9
    set_all(1, 2);
    run_frame(4, 4, 0, 1'b0, 1'b0);

    // Centre tap only over a 5x3 ramp: sum reproduces the input
    set_all(0, 3);
    set_w(4, 1);
    run_frame(5, 3, 1, 1'b0, 1'b0);

    // Most negative operands everywhere
    set_all(-128, -128);
    run_frame(2, 2, 2, 1'b0, 1'b0);

    // Top-centre tap only at full width with random backpressure
    set_all(0, 1);
    set_w(1, 1);
    run_frame(56, 4, 3, 1'b1, 1'b0);

    // Illegal width is rejected with a one-cycle error pulse
    cfg_width = 6'd1; cfg_height = 6'd2; start = 1'b1;
    step();
    start = 1'b0;
    check_val("cfg_err_pulse", cfg_err, 1);
    check_val("cfg_err_busy", busy, 0);
    step();
    check_val("cfg_err_clear", cfg_err, 0);
    set_all(0, 3);
    set_w(4, 1);
    run_frame(2, 2, 1, 1'b0, 1'b1);

    // Abort an 8x8 frame after ten inputs
    set_all(1, 2);
    cfg_width = 6'd8; cfg_height = 6'd8; start = 1'b1;
    step();
    start = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 10 && cyc < 100) begin
      in_valid = 1'b1; in_data = 8'sd1; out_ready = 1'b1;
      #4;
      if (in_ready) acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check_val("abort_fed", acc, 10);
    rst = 1'b1;
    step();
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_in_ready", in_ready, 0);
    rst = 1'b0;
    step();
    set_all(1, 2);
    run_frame(3, 3, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
